// File: rtl/movegen_sched.sv
// Move-generation scheduler: scans a 64-byte board in SDRAM, dispatches each piece of the
// side to move to its generator, and packs generator output boards contiguously at dest.

module movegen_piece_dec (
    input  logic [7:0] sq,
    input  logic       player,
    output logic [5:0] sel
);
    logic       own;
    logic [7:0] mag;

    // Sign is colour (positive white); -128 folds to 128 and is rejected as out of range.
    always_comb begin
        own = player ? (!sq[7] && (sq != 8'd0)) : sq[7];
        mag = sq[7] ? (8'd0 - sq) : sq;
        sel = 6'd0;
        if (own) begin
            if (mag <= 8'd8)       sel = 6'b000001;
            else if (mag <= 8'd18) sel = 6'b000010;
            else if (mag <= 8'd28) sel = 6'b000100;
            else if (mag <= 8'd38) sel = 6'b001000;
            else if (mag <= 8'd47) sel = 6'b010000;
            else if (mag == 8'd48) sel = 6'b100000;
        end
    end
endmodule

module movegen_sched (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    output logic [31:0] slave_readdata,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic [5:0]  gen_sel,
    input  logic        gen_waitrequest,
    output logic [3:0]  gen_address,
    output logic        gen_read,
    output logic        gen_write,
    output logic [31:0] gen_writedata,
    input  logic [31:0] gen_readdata
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD_REQ  = 4'd1;
    localparam logic [3:0] S_RD_WAIT = 4'd2;
    localparam logic [3:0] S_DECODE  = 4'd3;
    localparam logic [3:0] S_G_BOARD = 4'd4;
    localparam logic [3:0] S_G_DEST  = 4'd5;
    localparam logic [3:0] S_G_X     = 4'd6;
    localparam logic [3:0] S_G_Y     = 4'd7;
    localparam logic [3:0] S_G_START = 4'd8;
    localparam logic [3:0] S_G_POLL  = 4'd9;
    localparam logic [3:0] S_NEXT    = 4'd10;
    localparam logic [3:0] S_DONE    = 4'd11;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } gen_req_t;

    logic [3:0]  state;
    logic [31:0] board_addr;
    logic [31:0] dest_base;
    logic        player;
    logic [31:0] total;
    logic [31:0] cur_dest;
    logic [5:0]  idx;
    logic [7:0]  sq;
    logic [5:0]  dec_sel;
    gen_req_t    greq;
    logic        busy;
    logic        access;
    logic        done_rd0;
    logic        unused_bits;

    assign unused_bits = ^master_readdata[31:8];

    movegen_piece_dec u_dec (
        .sq     (sq),
        .player (player),
        .sel    (dec_sel)
    );

    assign busy     = (state >= S_RD_REQ) && (state <= S_NEXT);
    assign access   = slave_read || slave_write;
    assign done_rd0 = (state == S_DONE) && slave_read && (slave_address == 4'd0);

    assign slave_waitrequest = access && (busy || ((state == S_DONE) && !done_rd0));

    always_comb begin
        slave_readdata = 32'd0;
        if (slave_read && state == S_IDLE) begin
            case (slave_address)
                4'd0:    slave_readdata = total;
                4'd1:    slave_readdata = board_addr;
                4'd2:    slave_readdata = dest_base;
                4'd3:    slave_readdata = {31'd0, player};
                default: slave_readdata = 32'd0;
            endcase
        end else if (done_rd0) begin
            slave_readdata = total;
        end
    end

    assign master_read    = (state == S_RD_REQ);
    assign master_address = master_read ? (board_addr + {26'd0, idx}) : 32'd0;

    // One generator register access per dispatch state; strobes come straight from state.
    always_comb begin
        greq = '0;
        case (state)
            S_G_BOARD: greq = '{rd: 1'b0, wr: 1'b1, addr: 4'd1, data: board_addr};
            S_G_DEST:  greq = '{rd: 1'b0, wr: 1'b1, addr: 4'd2, data: cur_dest};
            S_G_X:     greq = '{rd: 1'b0, wr: 1'b1, addr: 4'd3, data: {29'd0, idx[2:0]}};
            S_G_Y:     greq = '{rd: 1'b0, wr: 1'b1, addr: 4'd4, data: {29'd0, idx[5:3]}};
            S_G_START: greq = '{rd: 1'b0, wr: 1'b1, addr: 4'd0, data: 32'd0};
            S_G_POLL:  greq = '{rd: 1'b1, wr: 1'b0, addr: 4'd0, data: 32'd0};
            default:   greq = '0;
        endcase
    end

    assign gen_read      = greq.rd;
    assign gen_write     = greq.wr;
    assign gen_address   = greq.addr;
    assign gen_writedata = greq.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            board_addr <= 32'd0;
            dest_base  <= 32'd0;
            player     <= 1'b0;
            total      <= 32'd0;
            cur_dest   <= 32'd0;
            idx        <= 6'd0;
            sq         <= 8'd0;
            gen_sel    <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (slave_write) begin
                        case (slave_address)
                            4'd0: begin
                                idx      <= 6'd0;
                                total    <= 32'd0;
                                cur_dest <= dest_base;
                                state    <= S_RD_REQ;
                            end
                            4'd1:    board_addr <= slave_writedata;
                            4'd2:    dest_base  <= slave_writedata;
                            4'd3:    player     <= slave_writedata[0];
                            default: ;
                        endcase
                    end
                end
                S_RD_REQ:  if (!master_waitrequest) state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        sq    <= master_readdata[7:0];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_sel != 6'd0) begin
                        gen_sel <= dec_sel;
                        state   <= S_G_BOARD;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_G_BOARD: if (!gen_waitrequest) state <= S_G_DEST;
                S_G_DEST:  if (!gen_waitrequest) state <= S_G_X;
                S_G_X:     if (!gen_waitrequest) state <= S_G_Y;
                S_G_Y:     if (!gen_waitrequest) state <= S_G_START;
                S_G_START: if (!gen_waitrequest) state <= S_G_POLL;
                S_G_POLL: begin
                    // Each output board is 64 bytes, so the next free slot moves by count*64.
                    if (!gen_waitrequest) begin
                        total    <= total + gen_readdata;
                        cur_dest <= cur_dest + {gen_readdata[25:0], 6'd0};
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    gen_sel <= 6'd0;
                    if (idx == 6'd63) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 6'd1;
                        state <= S_RD_REQ;
                    end
                end
                S_DONE:  if (done_rd0) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_movegen_sched.sv
// Randomized scoreboard bench for movegen_sched with SDRAM and generator mocks.

module tb_movegen_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = 4'd0;
    logic        slave_read = 1'b0;
    logic        slave_write = 1'b0;
    logic [31:0] slave_readdata;
    logic [31:0] slave_writedata = 32'd0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = 32'd0;
    logic        master_readdatavalid = 1'b0;
    logic [5:0]  gen_sel;
    logic        gen_waitrequest = 1'b0;
    logic [3:0]  gen_address;
    logic        gen_read;
    logic        gen_write;
    logic [31:0] gen_writedata;
    logic [31:0] gen_readdata = 32'd0;

    movegen_sched dut (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
        .slave_read(slave_read), .slave_write(slave_write),
        .slave_readdata(slave_readdata), .slave_writedata(slave_writedata),
        .master_waitrequest(master_waitrequest), .master_address(master_address),
        .master_read(master_read), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .gen_sel(gen_sel), .gen_waitrequest(gen_waitrequest), .gen_address(gen_address),
        .gen_read(gen_read), .gen_write(gen_write), .gen_writedata(gen_writedata),
        .gen_readdata(gen_readdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [5:0]  sel;
        logic [3:0]  addr;
        logic [31:0] data;
    } gacc_t;
    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } hrd_t;

    gacc_t       exp_gen[$];
    logic [31:0] exp_mrd[$];
    hrd_t        exp_hps[$];

    logic signed [7:0] mem[64];
    logic [31:0] ret_tab[6];
    logic [31:0] cfg_board = 32'd0;
    bit          stall_en = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [7:0]  pend_byte = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic err(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=unexpected required=none", name);
    endtask

    // SDRAM mock: accept on handshake, return the byte 0..5 cycles later with junk upper bits.
    always @(negedge clk) begin
        if (rst_n && master_read && !master_waitrequest) begin
            if (exp_mrd.size() == 0) err("mrd_unexpected");
            else chk("mrd_addr", master_address, exp_mrd.pop_front());
            pend      = 1'b1;
            pend_byte = mem[6'(master_address - cfg_board)];
            pend_cnt  = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pend = 1'b0;
            master_readdatavalid = 1'b0;
        end else if (pend && pend_cnt == 0) begin
            master_readdatavalid = 1'b1;
            master_readdata = {24'($urandom), pend_byte};
            pend = 1'b0;
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata = $urandom;
            if (pend) pend_cnt--;
        end
        master_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        gen_waitrequest    = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Generator mock: every completed access is scored; start arms the return count for the poll.
    always @(negedge clk) begin
        if (rst_n && (gen_write || gen_read) && !gen_waitrequest) begin
            if (exp_gen.size() == 0) begin
                err("gen_unexpected");
            end else begin
                gacc_t e;
                e = exp_gen.pop_front();
                chk("gen_rd", {31'd0, gen_read}, {31'd0, e.rd});
                chk("gen_sel", {26'd0, gen_sel}, {26'd0, e.sel});
                chk("gen_addr", {28'd0, gen_address}, {28'd0, e.addr});
                if (!e.rd) chk("gen_data", gen_writedata, e.data);
            end
            if (gen_write && gen_address == 4'd0)
                for (int k = 0; k < 6; k++) if (gen_sel[k]) gen_readdata = ret_tab[k];
        end
    end

    always @(negedge clk) begin
        if (slave_read && !slave_waitrequest) begin
            if (exp_hps.size() == 0) begin
                err("hps_unexpected_read");
            end else begin
                hrd_t h;
                h = exp_hps.pop_front();
                chk("hps_addr", {28'd0, slave_address}, {28'd0, h.a});
                chk("hps_rdata", slave_readdata, h.d);
            end
        end
    end

    task automatic summary_and_finish();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic hps_access(input bit wr, input logic [3:0] a, input logic [31:0] d,
                              input int budget, output int n);
        @(posedge clk); #1;
        slave_address = a; slave_write = wr; slave_read = !wr; slave_writedata = d;
        if (wr && a == 4'd1) cfg_board = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (slave_waitrequest && n < budget);
        if (slave_waitrequest) begin
            checks++; failures++;
            $display("FAIL hps_timeout addr=%0d waited=%0d required<=%0d", a, n, budget);
            summary_and_finish();
        end
        last_cyc = cyc;
        @(posedge clk); #1;
        slave_read = 1'b0; slave_write = 1'b0;
    endtask

    task automatic hps_read(input logic [3:0] a, input logic [31:0] exp, input int budget,
                            output int n);
        exp_hps.push_back('{a: a, d: exp});
        hps_access(1'b0, a, 32'd0, budget, n);
    endtask

    // Reference: walk squares in order, decode by range and colour, queue every expected access.
    task automatic run_model(input logic [31:0] board, input logic [31:0] dest, input bit pl,
                             output logic [31:0] tot);
        logic [31:0] cur;
        int v, a, t;
        cur = dest; tot = 32'd0;
        for (int i = 0; i < 64; i++) begin
            exp_mrd.push_back(board + i);
            v = mem[i];
            a = (v < 0) ? -v : v;
            t = -1;
            if ((pl && v > 0) || (!pl && v < 0)) begin
                if (a <= 8) t = 0;
                else if (a <= 18) t = 1;
                else if (a <= 28) t = 2;
                else if (a <= 38) t = 3;
                else if (a <= 47) t = 4;
                else if (a == 48) t = 5;
            end
            if (t >= 0) begin
                logic [5:0] s;
                s = 6'(1 << t);
                exp_gen.push_back('{rd: 1'b0, sel: s, addr: 4'd1, data: board});
                exp_gen.push_back('{rd: 1'b0, sel: s, addr: 4'd2, data: cur});
                exp_gen.push_back('{rd: 1'b0, sel: s, addr: 4'd3, data: i % 8});
                exp_gen.push_back('{rd: 1'b0, sel: s, addr: 4'd4, data: i / 8});
                exp_gen.push_back('{rd: 1'b0, sel: s, addr: 4'd0, data: 32'd0});
                exp_gen.push_back('{rd: 1'b1, sel: s, addr: 4'd0, data: 32'd0});
                tot = tot + ret_tab[t];
                cur = cur + (ret_tab[t] << 6);
            end
        end
    endtask

    task automatic do_run(input logic [31:0] board, input logic [31:0] dest, input bit pl,
                          input bit chk_cycles, input string tag);
        logic [31:0] tot;
        int n, c0;
        run_model(board, dest, pl, tot);
        hps_access(1'b1, 4'd1, board, 4, n);
        hps_access(1'b1, 4'd2, dest, 4, n);
        hps_access(1'b1, 4'd3, ($urandom & 32'hFFFF_FFFE) | {31'd0, pl}, 4, n);
        hps_read(4'd1, board, 4, n);
        hps_read(4'd2, dest, 4, n);
        hps_read(4'd3, {31'd0, pl}, 4, n);
        hps_access(1'b1, 4'd0, $urandom, 4, n);
        c0 = last_cyc;
        hps_read(4'd0, tot, 40000, n);
        if (chk_cycles) chk({"run_cycles_le_257 ", tag}, 32'(last_cyc - c0 <= 257), 32'd1);
        chk({"mrd_leftover ", tag}, exp_mrd.size(), 32'd0);
        chk({"gen_leftover ", tag}, exp_gen.size(), 32'd0);
        hps_read(4'd0, tot, 4, n);
        chk({"idle_rd0_nostall ", tag}, n, 32'd1);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) mem[i] = 8'sd0;
    endtask

    task automatic rand_board();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 2) == 0) mem[i] = 8'sd0;
            else if ($urandom_range(0, 1) == 0) mem[i] = 8'($urandom);
            else mem[i] = 8'($urandom_range(1, 48)) * (($urandom_range(0, 1) == 1) ? 8'sd1 : -8'sd1);
        end
    endtask

    initial begin
        int n;
        clear_board();
        for (int k = 0; k < 6; k++) ret_tab[k] = 32'd0;
        #2;
        chk("rst_slave_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
        chk("rst_slave_readdata", slave_readdata, 32'd0);
        chk("rst_master_read", {31'd0, master_read}, 32'd0);
        chk("rst_master_address", master_address, 32'd0);
        chk("rst_gen_sel", {26'd0, gen_sel}, 32'd0);
        chk("rst_gen_read", {31'd0, gen_read}, 32'd0);
        chk("rst_gen_write", {31'd0, gen_write}, 32'd0);
        chk("rst_gen_address", {28'd0, gen_address}, 32'd0);
        chk("rst_gen_writedata", gen_writedata, 32'd0);
        #20 rst_n = 1'b1;
        hps_read(4'd0, 32'd0, 4, n);

        // Empty board, white: 64 reads, nothing dispatched, within the cycle bound.
        do_run(32'h0000_4000, 32'h0000_1000, 1'b1, 1'b1, "empty");

        // Single white pawn at x=2,y=1.
        clear_board(); mem[10] = 8'sh03; ret_tab[0] = 32'd2;
        do_run(32'h0000_8000, 32'h0000_1000, 1'b1, 1'b0, "pawn");

        // Knight at idx 1, king at idx 4.
        clear_board(); mem[1] = 8'sd19; mem[4] = 8'sd48; ret_tab[2] = 32'd3; ret_tab[5] = 32'd5;
        do_run(32'h0001_0000, 32'h0000_2000, 1'b1, 1'b0, "knight_king");

        // Black to move on a mixed board, including out-of-range bytes and the last square.
        clear_board();
        mem[0] = -8'sd1; mem[2] = 8'sd5; mem[3] = 8'sh31; mem[5] = -8'sd49; mem[7] = -8'sd48;
        mem[9] = -8'sd20; mem[12] = -8'sd128; mem[20] = 8'sd30; mem[33] = -8'sd9;
        mem[40] = -8'sd38; mem[63] = -8'sd40;
        for (int k = 0; k < 6; k++) ret_tab[k] = $urandom_range(0, 9);
        do_run(32'h0002_0000, 32'h0000_3000, 1'b0, 1'b0, "black");

        // Same board under random stalls and read latency.
        stall_en = 1'b1;
        do_run(32'h0002_0000, 32'h0000_3000, 1'b0, 1'b0, "black_stall");

        for (int r = 0; r < 5; r++) begin
            rand_board();
            for (int k = 0; k < 6; k++)
                ret_tab[k] = (r == 4) ? $urandom : 32'($urandom_range(0, 20));
            do_run($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, "random");
        end

        // Asynchronous reset while writing the X register.
        stall_en = 1'b0;
        clear_board(); mem[0] = 8'sd1; mem[9] = 8'sd12; ret_tab[0] = 32'd4; ret_tab[1] = 32'd6;
        begin
            logic [31:0] tot;
            bit found;
            run_model(32'h0000_0100, 32'h0000_0800, 1'b1, tot);
            hps_access(1'b1, 4'd1, 32'h0000_0100, 4, n);
            hps_access(1'b1, 4'd2, 32'h0000_0800, 4, n);
            hps_access(1'b1, 4'd3, 32'd1, 4, n);
            hps_access(1'b1, 4'd0, 32'd0, 4, n);
            found = 1'b0;
            for (int i = 0; i < 2000 && !found; i++) begin
                @(negedge clk);
                if (gen_write && gen_address == 4'd3) found = 1'b1;
            end
            if (!found) err("reset_gx_not_reached");
            rst_n = 1'b0;
            #1;
            chk("rstmid_master_read", {31'd0, master_read}, 32'd0);
            chk("rstmid_gen_write", {31'd0, gen_write}, 32'd0);
            chk("rstmid_gen_read", {31'd0, gen_read}, 32'd0);
            chk("rstmid_gen_sel", {26'd0, gen_sel}, 32'd0);
            exp_gen.delete(); exp_mrd.delete();
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            hps_read(4'd1, 32'd0, 4, n);
            hps_read(4'd0, 32'd0, 4, n);
        end
        do_run(32'h0000_0100, 32'h0000_0800, 1'b1, 1'b0, "after_reset");

        chk("hps_leftover", exp_hps.size(), 32'd0);
        summary_and_finish();
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
